cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 119 +++++++++++
 tb/tb_cache_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Blocking cache controller FSM: lookup, dirty write-back, refill and retry,
// with saturating hit/miss/write-back statistics counters.
module cache_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_valid,
  input  logic             cpu_req_type,
  output logic             cpu_ready,
  output logic             cpu_stall,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  output logic             read_en_cache,
  output logic             write_en_cache,
  output logic             ready_mem,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             addr_sel,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   req_wr, req_wr_nxt;
  logic   retry, retry_nxt;
  logic   hit_inc, miss_inc, wb_inc;

  // State, latched request type, retry flag and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      req_wr   <= 1'b0;
      retry    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      req_wr <= req_wr_nxt;
      retry  <= retry_nxt;
      if (hit_inc && hit_cnt != CNT_MAX)   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      if (wb_inc && wb_cnt != CNT_MAX)     wb_cnt   <= wb_cnt + CNT_W'(1);
    end
  end

  // Next state and strobes; hit response and refill strobes are Mealy on the
  // cache/memory handshake inputs so they land in the same cycle.
  always_comb begin
    state_nxt      = state;
    req_wr_nxt     = req_wr;
    retry_nxt      = retry;
    cpu_ready      = 1'b0;
    cpu_stall      = 1'b1;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    ready_mem      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    addr_sel       = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_stall = 1'b0;
        if (cpu_valid) begin
          req_wr_nxt = cpu_req_type;
          retry_nxt  = 1'b0;
          state_nxt  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        read_en_cache  = ~req_wr;
        write_en_cache = req_wr;
        if (cache_hit) begin
          cpu_ready = 1'b1;
          hit_inc   = ~retry;
          state_nxt = S_IDLE;
        end else begin
          miss_inc  = ~retry;
          retry_nxt = 1'b1;
          state_nxt = cache_dirty ? S_WRITE_BACK : S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          wb_inc    = 1'b1;
          state_nxt = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ready_mem      = 1'b1;
          write_en_cache = 1'b1;
          state_nxt      = S_COMPARE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a 4-line cache array model answers
// lookups, and per-transaction latency/counter predictions are checked.
module tb_cache_controller;

  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_valid, cpu_req_type, cpu_ready, cpu_stall;
  logic             cache_hit, cache_dirty;
  logic             read_en_cache, write_en_cache, ready_mem;
  logic             mem_req, mem_we, mem_ack, addr_sel;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

  cache_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_req_type(cpu_req_type),
    .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .ready_mem(ready_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .addr_sel(addr_sel),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  // Cache array model: valid/dirty/tag per line, looked up by the current address
  logic       line_valid [4];
  logic       line_dirty [4];
  logic [1:0] line_tag   [4];
  logic [1:0] cur_idx, cur_tag;

  always_comb begin
    cache_hit   = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
    cache_dirty = line_dirty[cur_idx];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int hit_e = 0, miss_e = 0, wb_e = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_counters(input string where);
    check({where, "_hit_cnt"}, 32'(hit_cnt), 32'(hit_e));
    check({where, "_miss_cnt"}, 32'(miss_cnt), 32'(miss_e));
    check({where, "_wb_cnt"}, 32'(wb_cnt), 32'(wb_e));
  endtask

  // One CPU request; entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input logic wr, input logic [1:0] idx, input logic [1:0] tg,
                         input int d, input logic lose);
    logic exp_hit, exp_wb, lose_pend, wb_pend, done, mr, ack_now, rm, hit_now;
    int exp_lat, exp_mem, lat, mem_cycles, readies, ph_cnt;
    cur_idx = idx;
    cur_tag = tg;
    exp_hit = line_valid[idx] && (line_tag[idx] == tg);
    exp_wb  = !exp_hit && line_dirty[idx];
    lose_pend = lose && !exp_hit;
    exp_mem = exp_hit ? 0 : (exp_wb ? d + 1 : 0) + (d + 1) + (lose_pend ? d + 1 : 0);
    exp_lat = exp_hit ? 1 : exp_mem + 2 + (lose_pend ? 1 : 0);
    if (exp_hit) hit_e = sat_inc(hit_e);
    else miss_e = sat_inc(miss_e);
    if (exp_wb) wb_e = sat_inc(wb_e);

    cpu_valid = 1'b1;
    cpu_req_type = wr;
    @(negedge clk);
    check("accepted_stall", 32'(cpu_stall), 32'd1);
    wb_pend = exp_wb;
    done = 1'b0;
    lat = 0; mem_cycles = 0; readies = 0; ph_cnt = 0;
    while (!done && lat < 200) begin
      lat++;
      cpu_valid    = 1'($urandom_range(1));
      cpu_req_type = 1'($urandom_range(1));
      mem_ack = mem_req ? (ph_cnt == d) : 1'($urandom_range(1));
      #1;
      check("busy_stall", 32'(cpu_stall), 32'd1);
      if (mem_req) begin
        mem_cycles++;
        check("mem_we", 32'(mem_we), 32'(wb_pend));
        check("addr_sel", 32'(addr_sel), 32'(wb_pend));
        check("refill_rdy", 32'(ready_mem), 32'(mem_ack && !wb_pend));
        check("refill_wen", 32'(write_en_cache), 32'(mem_ack && !wb_pend));
        check("mem_no_lookup", 32'(read_en_cache), 32'd0);
      end else begin
        check("lookup_rd", 32'(read_en_cache), 32'(!wr));
        check("lookup_wr", 32'(write_en_cache), 32'(wr));
        check("lookup_no_refill", 32'(ready_mem), 32'd0);
      end
      check("cpu_ready", 32'(cpu_ready), 32'(!mem_req && cache_hit));
      if (cpu_ready) readies++;
      mr = mem_req;
      ack_now = mem_req && mem_ack;
      rm = ready_mem;
      hit_now = !mem_req && cache_hit;
      @(posedge clk);
      if (mr) ph_cnt = ack_now ? 0 : ph_cnt + 1;
      if (ack_now && wb_pend) wb_pend = 1'b0;
      if (rm) begin
        if (lose_pend) begin
          line_valid[idx] = 1'b0;
          line_dirty[idx] = 1'b0;
          lose_pend = 1'b0;
        end else begin
          line_valid[idx] = 1'b1;
          line_dirty[idx] = 1'b0;
          line_tag[idx]   = tg;
        end
      end
      if (hit_now) begin
        if (wr) line_dirty[idx] = 1'b1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    cpu_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_cycles", 32'(mem_cycles), 32'(exp_mem));
    check("ready_pulses", 32'(readies), 32'd1);
    check("back_to_idle", 32'(cpu_stall), 32'd0);
    check_counters("txn");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_valid = 1'b0;
      cpu_req_type = 1'($urandom_range(1));
      mem_ack = 1'($urandom_range(1));
      #1;
      check("idle_stall", 32'(cpu_stall), 32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
      check("idle_ready_mem", 32'(ready_mem), 32'd0);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check_counters("idle");
  endtask

  task automatic random_txns(input int n);
    for (int i = 0; i < n; i++) begin
      run_txn(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
              int'($urandom_range(6)), ($urandom_range(5) == 0));
      if ($urandom_range(3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
  endtask

  // Abort a clean-miss refill with reset, then show a late ack is ignored
  task automatic reset_in_allocate();
    line_valid[0] = 1'b0;
    line_dirty[0] = 1'b0;
    cur_idx = 2'd0;
    cur_tag = 2'd1;
    cpu_valid = 1'b1;
    cpu_req_type = 1'b0;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_mem_req", 32'(mem_req), 32'd1);
    check("rst_pre_mem_we", 32'(mem_we), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_wen", 32'(write_en_cache), 32'd0);
    hit_e = 0; miss_e = 0; wb_e = 0;
    check_counters("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("late_ack_ready_mem", 32'(ready_mem), 32'd0);
    check("late_ack_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_stall", 32'(cpu_stall), 32'd0);
    check_counters("post_rst");
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      line_valid[i] = 1'b0;
      line_dirty[i] = 1'b0;
      line_tag[i]   = 2'd0;
    end
    cur_idx = 2'd0;
    cur_tag = 2'd0;
    rst = 1'b1;
    cpu_valid = 1'b0;
    cpu_req_type = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("reset_stall", 32'(cpu_stall), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_ready", 32'(cpu_ready), 32'd0);
    check_counters("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed: clean read miss, read hit, write hit, dirty read miss
    run_txn(1'b0, 2'd1, 2'd2, 5, 1'b0);
    run_txn(1'b0, 2'd1, 2'd2, 0, 1'b0);
    run_txn(1'b1, 2'd1, 2'd2, 0, 1'b0);
    run_txn(1'b0, 2'd1, 2'd3, 2, 1'b0);
    // Write miss clean, then a retry that misses again
    run_txn(1'b1, 2'd2, 2'd0, 1, 1'b0);
    run_txn(1'b0, 2'd3, 2'd1, 3, 1'b1);

    random_txns(60);
    reset_in_allocate();
    random_txns(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
